// File: rtl/pwm_multi.sv
// pwm_multi: one shared prescaler and period counter driving CHANNELS double-buffered PWM outputs.
// Define MULTI_PWM_CENTER_ALIGN_EN for a triangle (center-aligned) counter; default build is edge-aligned.
module pwm_multi #(
   parameter int CHANNELS = 4,
   parameter int AW       = 2,
   parameter int DUTY_W   = 16,
   parameter int CNT_W    = 17,
   parameter int PERIOD   = 80000,
   parameter int PRESCALE = 3
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                en,
   input  logic                wen,
   input  logic [AW-1:0]       waddr,
   input  logic [DUTY_W-1:0]   wdata,
   output logic [CHANNELS-1:0] out,
   output logic                period_start
);

   localparam int CW = (CNT_W > DUTY_W) ? CNT_W : DUTY_W;
   localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
   localparam logic [PW-1:0]    PRESC_LAST = PW'(PRESCALE - 1);
   localparam logic [PW-1:0]    PRESC_ZERO = {PW{1'b0}};
   localparam logic [PW-1:0]    PRESC_ONE  = PW'(1);
   localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(PERIOD - 1);
   localparam logic [CNT_W-1:0] CNT_ZERO   = {CNT_W{1'b0}};
   localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
   localparam logic [DUTY_W-1:0] DUTY_ZERO = {DUTY_W{1'b0}};

   logic [PW-1:0]       presc_r;
   logic [CNT_W-1:0]    cnt_r;
   logic                run_r;
   logic [DUTY_W-1:0]   shadow_r [CHANNELS];
   logic [DUTY_W-1:0]   active_r [CHANNELS];
   logic [CHANNELS-1:0] out_r;
   logic                pstart_r;

   logic                start_s;
   logic                tick_s;
   logic                wrap_s;
   logic [CNT_W-1:0]    step_cnt_s;
   logic [CHANNELS-1:0] cmp_s;
   logic [CHANNELS-1:0] start_out_s;
`ifdef MULTI_PWM_CENTER_ALIGN_EN
   logic                dir_r;
   logic                step_up_s;
`endif

   // Start is the first enabled cycle after a stop; ticks only come from a running prescaler.
   always_comb begin
      start_s = 1'b0;
      tick_s  = 1'b0;
      if (en && !run_r) begin
         start_s = 1'b1;
      end else begin
         start_s = 1'b0;
      end
      if (en && run_r && (presc_r == PRESC_LAST)) begin
         tick_s = 1'b1;
      end else begin
         tick_s = 1'b0;
      end
   end

`ifdef MULTI_PWM_CENTER_ALIGN_EN
   // Triangle successor: up to PERIOD-1, down to 0, turning up again at the valley.
   always_comb begin
      step_cnt_s = cnt_r;
      step_up_s  = dir_r;
      if (cnt_r == CNT_ZERO) begin
         step_cnt_s = CNT_ONE;
         step_up_s  = 1'b1;
      end else if (dir_r && (cnt_r < CNT_LAST)) begin
         step_cnt_s = cnt_r + CNT_ONE;
         step_up_s  = 1'b1;
      end else begin
         step_cnt_s = cnt_r - CNT_ONE;
         step_up_s  = (cnt_r == CNT_ONE);
      end
   end
`else
   // Sawtooth successor: wrap to 0 after PERIOD-1.
   always_comb begin
      step_cnt_s = cnt_r;
      if (cnt_r >= CNT_LAST) begin
         step_cnt_s = CNT_ZERO;
      end else begin
         step_cnt_s = cnt_r + CNT_ONE;
      end
   end
`endif

   // At the boundary the compare uses the incoming shadow value so a new duty never leaves a runt.
   always_comb begin
      wrap_s      = 1'b0;
      cmp_s       = {CHANNELS{1'b0}};
      start_out_s = {CHANNELS{1'b0}};
      if (tick_s && (step_cnt_s == CNT_ZERO)) begin
         wrap_s = 1'b1;
      end else begin
         wrap_s = 1'b0;
      end
      for (int i = 0; i < CHANNELS; i++) begin
         if (wrap_s) begin
            cmp_s[i] = (CW'(step_cnt_s) < CW'(shadow_r[i]));
         end else begin
            cmp_s[i] = (CW'(step_cnt_s) < CW'(active_r[i]));
         end
         start_out_s[i] = (shadow_r[i] != DUTY_ZERO);
      end
   end

   // Host duty writes; out-of-range addresses match no channel.
   always_ff @(posedge clk) begin
      if (!rst) begin
         for (int i = 0; i < CHANNELS; i++) begin
            shadow_r[i] <= DUTY_ZERO;
         end
      end else begin
         for (int i = 0; i < CHANNELS; i++) begin
            if (wen && (waddr == AW'(i))) begin
               shadow_r[i] <= wdata;
            end else begin
               shadow_r[i] <= shadow_r[i];
            end
         end
      end
   end

   // Prescaler and period counter; held at 0 while stopped and on the restart cycle.
   always_ff @(posedge clk) begin
      if (!rst) begin
         presc_r <= PRESC_ZERO;
         cnt_r   <= CNT_ZERO;
         run_r   <= 1'b0;
`ifdef MULTI_PWM_CENTER_ALIGN_EN
         dir_r   <= 1'b1;
`endif
      end else begin
         run_r <= en;
         if (!en || !run_r) begin
            presc_r <= PRESC_ZERO;
            cnt_r   <= CNT_ZERO;
`ifdef MULTI_PWM_CENTER_ALIGN_EN
            dir_r   <= 1'b1;
`endif
         end else if (tick_s) begin
            presc_r <= PRESC_ZERO;
            cnt_r   <= step_cnt_s;
`ifdef MULTI_PWM_CENTER_ALIGN_EN
            dir_r   <= step_up_s;
`endif
         end else begin
            presc_r <= presc_r + PRESC_ONE;
            cnt_r   <= cnt_r;
`ifdef MULTI_PWM_CENTER_ALIGN_EN
            dir_r   <= dir_r;
`endif
         end
      end
   end

   // Active duty follows shadow while stopped, on restart, and at each period boundary.
   always_ff @(posedge clk) begin
      if (!rst) begin
         for (int i = 0; i < CHANNELS; i++) begin
            active_r[i] <= DUTY_ZERO;
         end
      end else if (!en || start_s || wrap_s) begin
         for (int i = 0; i < CHANNELS; i++) begin
            active_r[i] <= shadow_r[i];
         end
      end else begin
         for (int i = 0; i < CHANNELS; i++) begin
            active_r[i] <= active_r[i];
         end
      end
   end

   // Registered outputs; a restart opens a fresh period at count 0.
   always_ff @(posedge clk) begin
      if (!rst) begin
         out_r    <= {CHANNELS{1'b0}};
         pstart_r <= 1'b0;
      end else if (!en) begin
         out_r    <= {CHANNELS{1'b0}};
         pstart_r <= 1'b0;
      end else if (start_s) begin
         out_r    <= start_out_s;
         pstart_r <= 1'b1;
      end else begin
         pstart_r <= wrap_s;
         if (tick_s) begin
            out_r <= cmp_s;
         end else begin
            out_r <= out_r;
         end
      end
   end

   assign out          = out_r;
   assign period_start = pstart_r;

endmodule

// File: tb/tb_pwm_multi.sv
// Directed bench for pwm_multi with PERIOD=10, PRESCALE=3, CHANNELS=4, AW=3 (30-clk periods).
module tb_pwm_multi;

   localparam int CHANNELS = 4;
   localparam int AW       = 3;
   localparam int DUTY_W   = 16;
   localparam int CNT_W    = 17;
   localparam int PERIOD   = 10;
   localparam int PRESCALE = 3;

   logic                clk = 1'b0;
   logic                rst;
   logic                en;
   logic                wen;
   logic [AW-1:0]       waddr;
   logic [DUTY_W-1:0]   wdata;
   logic [CHANNELS-1:0] out;
   logic                period_start;

   int passed = 0;
   int total  = 0;
   int hi [CHANNELS];
   int bad_rise;

   always #5 clk = ~clk;

   pwm_multi #(
      .CHANNELS(CHANNELS), .AW(AW), .DUTY_W(DUTY_W), .CNT_W(CNT_W),
      .PERIOD(PERIOD), .PRESCALE(PRESCALE)
   ) dut (
      .clk(clk), .rst(rst), .en(en), .wen(wen), .waddr(waddr),
      .wdata(wdata), .out(out), .period_start(period_start)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
   endtask

   task automatic wr(input logic [AW-1:0] a, input logic [DUTY_W-1:0] d);
      wen   = 1'b1;
      waddr = a;
      wdata = d;
      step();
      wen   = 1'b0;
   endtask

   // Advance at least one cycle, then to the next period_start sample (bounded).
   task automatic wait_pstart(input string tag);
      int n;
      n = 0;
      step();
      while (period_start !== 1'b1 && n < 200) begin
         step();
         n++;
      end
      chk(tag, {31'd0, period_start}, 32'd1);
   endtask

   // Sample n cycles from the current one: per-channel high counts, rises off period_start.
   task automatic measure(input int n);
      logic [CHANNELS-1:0] prev;
      prev     = {CHANNELS{1'b0}};
      bad_rise = 0;
      for (int c = 0; c < CHANNELS; c++) hi[c] = 0;
      for (int k = 0; k < n; k++) begin
         for (int c = 0; c < CHANNELS; c++) begin
            if (out[c] === 1'b1) hi[c]++;
         end
         if (((out & ~prev) != {CHANNELS{1'b0}}) && (period_start !== 1'b1)) bad_rise++;
         prev = out;
         step();
      end
   endtask

   task automatic chk_hi(input string tag, input int e0, input int e1, input int e2, input int e3);
      chk({tag, "_ch0"}, hi[0], e0);
      chk({tag, "_ch1"}, hi[1], e1);
      chk({tag, "_ch2"}, hi[2], e2);
      chk({tag, "_ch3"}, hi[3], e3);
      chk({tag, "_rise"}, bad_rise, 0);
   endtask

   initial begin
      logic [CHANNELS-1:0] acc;
      logic [53:0]         cap;
      logic [2:0]          other;
      int                  hi0;

      rst   = 1'b0;
      en    = 1'b1;
      wen   = 1'b0;
      waddr = '0;
      wdata = '0;

      step();
      chk("rst_out_a", out, 4'b0000);
      chk("rst_ps_a", period_start, 1'b0);
      step();
      chk("rst_out_b", out, 4'b0000);
      chk("rst_ps_b", period_start, 1'b0);
      rst = 1'b1;

`ifdef MULTI_PWM_CENTER_ALIGN_EN
      wr(3'd0, 16'd3);
      wait_pstart("c_first_wrap");
      chk("c_wrap_out", out, 4'b0001);
      hi0   = 0;
      other = 3'b000;
      for (int k = 0; k < 54; k++) begin
         cap[k] = out[0];
         other  = other | out[3:1];
         if (out[0] === 1'b1) hi0++;
         step();
      end
      chk("c_high_clks", hi0, 15);
      chk("c_up_last_hi", cap[8], 1'b1);
      chk("c_up_first_lo", cap[9], 1'b0);
      chk("c_dn_last_lo", cap[47], 1'b0);
      chk("c_dn_first_hi", cap[48], 1'b1);
      chk("c_other_low", other, 3'b000);
      chk("c_period_54", period_start, 1'b1);
`else
      // Reset release: duty 5 is only seen after the first wrap.
      wr(3'd0, 16'd5);
      acc = out;
      repeat (29) begin
         step();
         acc = acc | out;
      end
      chk("idle_out", acc, 4'b0000);
      wait_pstart("first_wrap");
      chk("first_wrap_out", out, 4'b0001);
      measure(30);
      chk("duty5_ch0", hi[0], 15);

      wr(3'd0, 16'd4);
      wr(3'd1, 16'd0);
      wr(3'd2, 16'd10);
      wr(3'd3, 16'd7);
      wait_pstart("basic_align");
      measure(30);
      chk_hi("basic1", 12, 0, 30, 21);
      measure(30);
      chk_hi("basic2", 12, 0, 30, 21);

      // Mid-period write of ch0=2 during count 5.
      hi0 = 0;
      for (int k = 0; k < 30; k++) begin
         if (k == 15) begin
            wen   = 1'b1;
            waddr = 3'd0;
            wdata = 16'd2;
         end else begin
            wen = 1'b0;
         end
         if (out[0] === 1'b1) hi0++;
         step();
      end
      wen = 1'b0;
      chk("mid_cur_ch0", hi0, 12);
      chk("mid_align", period_start, 1'b1);
      measure(30);
      chk_hi("mid_next", 6, 0, 30, 21);

      // Write coinciding with the wrap tick (count 9, last prescaler cycle).
      repeat (29) step();
      wr(3'd1, 16'd8);
      chk("coll_align", period_start, 1'b1);
      measure(30);
      chk("coll_old_ch1", hi[1], 0);
      measure(30);
      chk_hi("coll_new", 6, 24, 30, 21);

      // Drop enable mid-period, write while stopped, then restart.
      repeat (10) step();
      en = 1'b0;
      step();
      chk("dis_out", out, 4'b0000);
      chk("dis_ps", period_start, 1'b0);
      wr(3'd0, 16'd1);
      wr(3'd5, 16'd1);
      step();
      chk("dis_hold_out", out, 4'b0000);
      en = 1'b1;
      step();
      chk("en_ps", period_start, 1'b1);
      chk("en_out", out, 4'b1111);
      measure(30);
      chk_hi("reen", 3, 24, 30, 21);
      chk("reen_period", period_start, 1'b1);
`endif

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
